// File: rtl/spi_flash_reader.sv
// spi_flash_reader: drives one flash READ through spi_master's byte streams.
// SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B plus one dummy byte).
module spi_flash_reader #(
  parameter int AW = 24,
  parameter int LW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    data,
  output logic          valid,
  output logic [7:0]    spi_in,
  input  logic          spi_get,
  output logic          spi_empty,
  input  logic [7:0]    spi_out,
  input  logic          spi_put
);
  localparam int NB = AW / 8;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         H   = NB + 2;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         H   = NB + 1;
`endif
  localparam int CW = LW + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [CW-1:0] r_tx;
  logic [CW-1:0] r_rx;
  logic [7:0]    r_data;
  logic          r_valid;
  logic [CW-1:0] w_total;
  logic          w_accept;
  logic          w_last_get;
  logic          w_rx_en;
  logic [7:0]    w_byte;

  assign w_total    = CW'(H) + CW'(r_len);
  assign w_accept   = (r_state == S_IDLE) && req && (len != '0);
  assign w_last_get = (r_state == S_SEND) && spi_get &&
                      (r_tx == w_total - CW'(1));
  assign w_rx_en    = spi_put &&
                      ((r_state == S_SEND) || (r_state == S_DRAIN));

  // Header byte by index; data-phase (and dummy) slots clock out 0x00
  always_comb begin
    w_byte = 8'h00;
    if (r_tx == '0) w_byte = CMD;
    for (int k = 0; k < NB; k++) begin
      if (r_tx == CW'(k + 1)) w_byte = r_addr[AW-1-8*k -: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SEND;
      S_SEND:  if (w_last_get) w_next = S_DRAIN;
      S_DRAIN: if (r_rx == w_total) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= addr;
        r_len  <= len;
        r_tx   <= '0;
        r_rx   <= '0;
      end
      if ((r_state == S_SEND) && spi_get) r_tx <= r_tx + CW'(1);
      // Header echo is counted but never surfaces on data/valid
      if (w_rx_en) begin
        r_rx <= r_rx + CW'(1);
        if (r_rx >= CW'(H)) begin
          r_data  <= spi_out;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign spi_empty = (r_state != S_SEND);
  assign spi_in    = (r_state == S_SEND) ? w_byte : 8'h00;
  assign data      = r_data;
  assign valid     = r_valid;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a loopback spi_master model.
// Expected frames follow SPI_FLASH_FAST_READ_EN when it is defined.
module tb_spi_flash_reader;
  typedef logic [7:0] bq_t[$];

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int H = 5;
`else
  localparam int H = 4;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req;
  logic [23:0] addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [7:0]  data;
  logic        valid;
  logic [7:0]  spi_in;
  logic        spi_get = 1'b0;
  logic        spi_empty;
  logic [7:0]  spi_out = 8'h00;
  logic        spi_put = 1'b0;

  spi_flash_reader #(.AW(24), .LW(16)) dut (
    .clock(clock), .reset(reset), .req(req), .addr(addr), .len(len),
    .busy(busy), .done(done), .data(data), .valid(valid),
    .spi_in(spi_in), .spi_get(spi_get), .spi_empty(spi_empty),
    .spi_out(spi_out), .spi_put(spi_put)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Written only by the master/monitor process
  bq_t  tx_log;
  bq_t  rx_log;
  int   dcnt = 0;
  int   falls = 0;
  int   stab_err = 0;
  // Written only by the stimulus process
  logic [7:0] resp [0:15];
  int   gap = 0;

  logic       prev_empty = 1'b1;
  logic       prev_get = 1'b0;
  logic [7:0] prev_in = 8'h00;
  logic       put_pend = 1'b0;
  logic [7:0] put_byte = 8'h00;
  int         fbase = 0;
  int         gcnt = 0;

  always @(negedge clock) begin
    int idx;
    if (valid === 1'b1) rx_log.push_back(data);
    if (done === 1'b1) dcnt++;
    if (!spi_empty && !prev_empty && !prev_get && spi_in !== prev_in)
      stab_err++;
    if (prev_empty && !spi_empty) begin
      falls++;
      fbase = tx_log.size();
    end
    prev_empty = spi_empty;
    prev_in    = spi_in;
    spi_put    = put_pend;
    spi_out    = put_byte;
    put_pend   = 1'b0;
    if (!spi_empty && gcnt == 0) begin
      spi_get = 1'b1;
      idx = tx_log.size() - fbase;
      put_byte = (idx < H) ? spi_in : resp[idx-H];
      tx_log.push_back(spi_in);
      put_pend = 1'b1;
      gcnt = gap;
    end else begin
      spi_get = 1'b0;
      if (gcnt > 0) gcnt--;
    end
    prev_get = spi_get;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(string tag, int txb, int rxb, bq_t etx, bq_t erx);
    chk({tag, "_txlen"}, tx_log.size() - txb, etx.size());
    for (int i = 0; i < etx.size(); i++)
      if (txb + i < tx_log.size())
        chk($sformatf("%s_tx%0d", tag, i), tx_log[txb+i], etx[i]);
    chk({tag, "_nvalid"}, rx_log.size() - rxb, erx.size());
    for (int i = 0; i < erx.size(); i++)
      if (rxb + i < rx_log.size())
        chk($sformatf("%s_rx%0d", tag, i), rx_log[rxb+i], erx[i]);
  endtask

  task automatic start(logic [23:0] a, logic [15:0] l);
    addr = a;
    len  = l;
    req  = 1'b1;
    step();
    req  = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_empty", spi_empty, 0);
  endtask

  task automatic wait_done(string tag, bit req_in_done);
    int d0 = dcnt;
    int n = 0;
    while (dcnt == d0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, dcnt - d0, 1);
    if (dcnt != d0) begin
      chk({tag, "_busy_in_done"}, busy, 1);
      if (req_in_done) begin
        addr = 24'h777777;
        len  = 16'd4;
        req  = 1'b1;
      end
      step();
      req = 1'b0;
      chk({tag, "_busy_after"}, busy, 0);
      chk({tag, "_empty_after"}, spi_empty, 1);
      chk({tag, "_done_after"}, done, 0);
    end
  endtask

  initial begin
    int txb, rxb, fb, d0, n;
    bq_t etx, erx;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    reset = 1'b1;
    req   = 1'b1;
    addr  = 24'h123456;
    len   = 16'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid, 0);
      chk("rst_empty", spi_empty, 1);
    end
    reset = 1'b0;
    req   = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_empty", spi_empty, 1);
    chk("post_rst_data", data, 0);
    chk("post_rst_in", spi_in, 0);

    // Basic read, one idle cycle between gets
    gap = 1;
    resp[0] = 8'hA5;
    resp[1] = 8'h5A;
    txb = tx_log.size(); rxb = rx_log.size(); fb = falls;
    start(24'h123456, 16'd2);
    wait_done("rd2", 1'b0);
`ifdef SPI_FLASH_FAST_READ_EN
    etx = '{8'h0B, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00};
`else
    etx = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
`endif
    erx = '{8'hA5, 8'h5A};
    chk_frame("rd2", txb, rxb, etx, erx);
    chk("rd2_one_frame", falls - fb, 1);

    // Zero length is ignored
    d0 = dcnt; fb = falls;
    addr = 24'h000001; len = 16'd0; req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("len0_busy", busy, 0);
      chk("len0_empty", spi_empty, 1);
      step();
    end
    chk("len0_no_done", dcnt - d0, 0);
    chk("len0_no_frame", falls - fb, 0);

    // Req while busy and req in the DONE cycle are both ignored
    gap = 0;
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
    txb = tx_log.size(); rxb = rx_log.size(); fb = falls;
    start(24'h010203, 16'd3);
    addr = 24'hABCDEF; len = 16'd5; req = 1'b1;
    step(); step(); step();
    req = 1'b0;
    wait_done("rd3", 1'b1);
`ifdef SPI_FLASH_FAST_READ_EN
    etx = '{8'h0B, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    etx = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00};
`endif
    erx = '{8'h11, 8'h22, 8'h33};
    chk_frame("rd3", txb, rxb, etx, erx);
    chk("rd3_one_frame", falls - fb, 1);
    step();
    chk("rd3_still_idle", busy, 0);

    // Reset after the second data byte of an 8-byte read
    gap = 1;
    for (int i = 0; i < 8; i++) resp[i] = 8'h80 + 8'(i);
    rxb = rx_log.size();
    start(24'h0A0B0C, 16'd8);
    n = 0;
    while (rx_log.size() - rxb < 2 && n < 200) begin
      step();
      n++;
    end
    chk("abort_two_bytes", rx_log.size() - rxb, 2);
    d0 = dcnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_empty", spi_empty, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_data", data, 0);
    rxb = rx_log.size();
    for (int i = 0; i < 6; i++) step();
    chk("abort_no_done", dcnt - d0, 0);
    chk("abort_no_valid", rx_log.size() - rxb, 0);
    chk("abort_idle", busy, 0);

    resp[0] = 8'hC3;
    txb = tx_log.size(); rxb = rx_log.size(); fb = falls;
    start(24'h000010, 16'd1);
    wait_done("rd1", 1'b0);
`ifdef SPI_FLASH_FAST_READ_EN
    etx = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
`else
    etx = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
`endif
    erx = '{8'hC3};
    chk_frame("rd1", txb, rxb, etx, erx);
    chk("rd1_one_frame", falls - fb, 1);

    chk("spi_in_stable", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Sequencer for the byte-stream SPI master. Turns one read request (address, length) into a flash READ transaction.
- Feeds the command, address and dummy bytes into the master's transmit stream; discards the header echo; hands read-data bytes to the consumer.
- Sits between a boot/config loader and spi_master. It owns the master's in/get/empty and out/put streams exclusively.

Parameters:
- AW, 24, flash address width in bits; must be a multiple of 8 (header address bytes = AW/8, MSB first).
- LW, 16, width of the length field; max transfer = 2^LW-1 bytes.

Ports:
- clock  input  1  single clock, shared with spi_master
- reset  input  1  synchronous, active-high
- req  input  1  start request, sampled in IDLE only
- addr  input  AW  flash byte address, captured with req
- len  input  LW  number of data bytes to read, captured with req
- busy  output  1  high from the accepted req through the done cycle
- done  output  1  one-cycle pulse when the transaction completes
- data  output  8  received data byte
- valid  output  1  one-cycle pulse, data valid (no backpressure)
- spi_in  output  8  byte offered to spi_master.in
- spi_get  input  1  spi_master.get: presented byte consumed this cycle
- spi_empty  output  1  to spi_master.empty; high holds CS inactive
- spi_out  input  8  spi_master.out
- spi_put  input  1  spi_master.put: received byte valid

Behaviour:
- Reset values: busy=0, done=0, valid=0, data=0, spi_empty=1, spi_in=0, all counters 0, state IDLE.
- Header H = command 0x03, then AW/8 address bytes MSB first. H = 4 when AW=24.
- Total frame T = H + len bytes. Tx counter and rx counter are each LW+3 bits wide, so T cannot overflow.
- IDLE:
  - req=1 and len!=0: latch addr/len, zero both counters, busy=1 next cycle, go to SEND.
  - req=1 and len=0: ignored; busy stays 0 and done is not pulsed.
- SEND:
  - spi_empty=0; spi_in = frame byte at index tx count. Bytes beyond H are 0x00.
  - On spi_get=1, tx count is incremented and spi_in updates the next cycle. The byte must not change while spi_get=0.
  - When spi_get=1 on byte T-1, assert spi_empty=1 from the next cycle and go to DRAIN.
  - spi_empty must never rise mid-frame; a gap would drop CS.
- Receive, active in SEND and DRAIN:
  - Every spi_put=1 increments rx count.
  - Puts with index < H are discarded.
  - Puts with index >= H: data<=spi_out, valid=1 for that single next cycle.
- DRAIN: wait until rx count == T, then go to DONE. A put arriving in the same cycle as the last get is counted normally.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0. A req in the DONE cycle is ignored.
- Ignored inputs:
  - req while busy is ignored; the latched addr/len are unaffected.
  - spi_get while spi_empty=1 is ignored.
  - spi_put in IDLE is ignored (no valid, no count).
- Reset mid-operation: immediate return to IDLE, spi_empty=1 the cycle after reset. Partial data is abandoned and done is not pulsed.
- Latency from req to first spi_empty=0: 1 cycle.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined: command byte 0x0B, and one 0x00 dummy byte is appended after the address, so H = AW/8 + 2.
- Undefined: command 0x03, H = AW/8 + 1.
- All counting and discard rules apply to the resulting H unchanged.

Test Plan:
- Reset asserted for 3 cycles with req=1 -> busy=0, done=0, valid=0, spi_empty=1 throughout and the cycle after.
- req addr=0x123456 len=2 with a loopback master model returning 0xA5,0x5A for data bytes -> tx sequence 03 12 34 56 00 00, contiguous with no spi_empty gap. Exactly 2 valid pulses with data A5 then 5A, then done pulse, then busy=0.
- req len=0 -> no spi_empty low, busy stays 0, no done.
- Second req (addr=0xABCDEF) asserted during a len=3 transfer -> ignored; tx address bytes remain those of the first request; 3 valid pulses only.
- reset asserted after the 2nd data put of a len=8 read -> next cycle spi_empty=1, busy=0, no done. A following req len=1 completes normally.
- With SPI_FLASH_FAST_READ_EN, addr=0x000010 len=1 -> tx 0B 00 00 10 00 00; the first 5 received bytes are discarded; 1 valid pulse; done.
